truth_scan_ctrl: RTL and testbench

TRUTH_SCAN_CTRL -- requirements
Module: truth_scan_ctrl

---
 rtl/archsys_pkg.sv | 16 +
 rtl/truth_scan_ctrl_settle_timer.sv | 27 ++
 rtl/truth_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_truth_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/archsys_pkg.sv
// Shared definitions for the truth-table scan controller: FSM encoding and
// default build parameters.
package archsys_pkg;

    localparam int N_DEFAULT      = 5;
    localparam int SETTLE_DEFAULT = 1;
    localparam int TMR_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_scan_ctrl_settle_timer.sv
// Loadable down-counter that times the settle window between driving x_out
// and sampling f_in.
module settle_timer
    import archsys_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_scan_ctrl.sv
// Exhaustive truth-table scanner: walks x_out over all 2^N inputs, samples
// f_in after a settle window and compares the result against a latched golden table.
module truth_scan_ctrl
    import archsys_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [(1<<N)-1:0] golden,
    input  logic              f_in,
    output logic [N-1:0]      x_out,
    output logic              busy,
    output logic              done,
    output logic [(1<<N)-1:0] table_out,
    output logic              pass,
    output logic [N:0]        err_cnt,
    output logic [N-1:0]      first_err,
    output logic              first_err_vld
);

    localparam int               W        = 1 << N;
    localparam logic [N-1:0]     LAST_IDX = '1;
    localparam logic [TMR_W-1:0] LOAD_VAL = (SETTLE > 0) ? TMR_W'(SETTLE - 1) : '0;
    localparam state_t           ST_STEP  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t           r_state, w_nxt;
    logic [N-1:0]     r_idx;
    logic [W-1:0]     r_golden;
    logic [W-1:0]     r_table;
    logic [N:0]       r_err_cnt;
    logic [N-1:0]     r_first_err;
    logic             r_first_vld;
    logic             r_pass;
    logic             w_zero, w_load, w_dec, w_accept, w_mis;
    logic [N:0]       w_err_nxt;

    assign w_accept  = (r_state == ST_IDLE) && start && !abort;
    assign w_mis     = (f_in != r_golden[r_idx]);
    assign w_err_nxt = r_err_cnt + (N+1)'(w_mis);
    assign w_load    = (w_nxt == ST_SETTLE) && (r_state != ST_SETTLE);
    assign w_dec     = (r_state == ST_SETTLE);

    settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_nxt = ST_STEP;
            ST_SETTLE: begin
                if (abort)       w_nxt = ST_IDLE;
                else if (w_zero) w_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)                  w_nxt = ST_IDLE;
                else if (r_idx == LAST_IDX) w_nxt = ST_DONE;
                else                        w_nxt = ST_STEP;
            end
            ST_DONE:   w_nxt = ST_IDLE;
            default:   w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SETTLE, ST_SAMPLE: busy = 1'b1;
            ST_DONE:              done = 1'b1;
            default: ;
        endcase
    end

    // pass is resolved on the final sample edge so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_golden    <= '0;
            r_table     <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_first_vld <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_golden    <= golden;
                        r_table     <= '0;
                        r_err_cnt   <= '0;
                        r_first_vld <= 1'b0;
                        r_pass      <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) r_pass <= 1'b0;
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        r_table[r_idx] <= f_in;
                        r_err_cnt      <= w_err_nxt;
                        if (w_mis && !r_first_vld) begin
                            r_first_err <= r_idx;
                            r_first_vld <= 1'b1;
                        end
                        if (r_idx == LAST_IDX)
                            r_pass <= (w_err_nxt == '0);
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out         = r_idx;
    assign table_out     = r_table;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err     = r_first_err;
    assign first_err_vld = r_first_vld;

endmodule

// File: tb/tb_truth_scan_ctrl.sv
// Self-checking bench for truth_scan_ctrl: fixed vectors, randomized function
// tables against a table-level model, and abort/restart/reset corner sequences.
module tb_truth_scan_ctrl;

    localparam int N = 5;
    localparam int W = 1 << N;

    typedef struct {
        int          fm;
        logic [31:0] g;
        logic [31:0] tbl;
        int          err;
        int          first;
        bit          vld;
        bit          ps;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, start0 = 1'b0;
    logic [31:0] golden = '0;
    logic [31:0] rnd_tbl = '0;
    int          fmode = 0;

    logic        f_in, busy, done, pass, fvld;
    logic [4:0]  x_out, ferr;
    logic [31:0] table_out;
    logic [5:0]  err_cnt;
    logic        f_in0, busy0, done0, pass0, fvld0;
    logic [4:0]  x_out0, ferr0;
    logic [31:0] table_out0;
    logic [5:0]  err_cnt0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign f_in  = (fmode == 0) ? 1'b1 : (fmode == 1) ? x_out[0]  : (fmode == 2) ? ~x_out[0]  : rnd_tbl[x_out];
    assign f_in0 = (fmode == 0) ? 1'b1 : (fmode == 1) ? x_out0[0] : (fmode == 2) ? ~x_out0[0] : rnd_tbl[x_out0];

    truth_scan_ctrl #(.N(N), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
        .f_in(f_in), .x_out(x_out), .busy(busy), .done(done), .table_out(table_out),
        .pass(pass), .err_cnt(err_cnt), .first_err(ferr), .first_err_vld(fvld)
    );

    truth_scan_ctrl #(.N(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .golden(golden),
        .f_in(f_in0), .x_out(x_out0), .busy(busy0), .done(done0), .table_out(table_out0),
        .pass(pass0), .err_cnt(err_cnt0), .first_err(ferr0), .first_err_vld(fvld0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // function under test as a whole table, straight from the stimulus definition
    function automatic logic [31:0] ftab(input int m);
        logic [31:0] t;
        for (int i = 0; i < W; i++) begin
            case (m)
                0:       t[i] = 1'b1;
                1:       t[i] = (i % 2) == 1;
                2:       t[i] = (i % 2) == 0;
                default: t[i] = rnd_tbl[i];
            endcase
        end
        return t;
    endfunction

    // expected result of scanning the first `upto` entries against g
    function automatic vec_t model(input int m, input logic [31:0] g, input int upto);
        vec_t        v;
        logic [31:0] f, mask, diff;
        f    = ftab(m);
        mask = (upto >= 32) ? 32'hFFFF_FFFF : ((32'h1 << upto) - 1);
        diff = (f ^ g) & mask;
        v.fm    = m;
        v.g     = g;
        v.tbl   = f & mask;
        v.err   = $countones(diff);
        v.vld   = (diff != 0);
        v.first = 0;
        for (int i = W - 1; i >= 0; i--) if (diff[i]) v.first = i;
        v.ps    = (upto >= 32) && (diff == 0);
        return v;
    endfunction

    task automatic check_res(input string tag, input bit which, input vec_t v);
        chk({tag, "_table"}, which ? table_out0 : table_out, v.tbl);
        chk({tag, "_err_cnt"}, which ? err_cnt0 : err_cnt, v.err);
        chk({tag, "_first_vld"}, which ? fvld0 : fvld, v.vld);
        if (v.vld) chk({tag, "_first_err"}, which ? ferr0 : ferr, v.first);
        chk({tag, "_pass"}, which ? pass0 : pass, v.ps);
    endtask

    // Runs one scan; latency counts the start-accepting edge as cycle 1.
    // disturb=1 re-pulses start and flips golden when x_out reaches 5.
    task automatic scan(input string tag, input bit which, input int disturb, input vec_t v, input int exp_lat);
        int lat;
        bit did;
        fmode = v.fm;
        @(negedge clk);
        golden = v.g;
        if (which) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        chk({tag, "_busy_on_start"}, which ? busy0 : busy, 1);
        chk({tag, "_x_out_start"}, which ? x_out0 : x_out, 0);
        lat = 1;
        did = 0;
        while (!(which ? done0 : done) && lat < 400) begin
            if (disturb == 1 && !did && x_out == 5) begin
                start  = 1'b1;
                golden = ~golden;
                did    = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_in_done"}, which ? busy0 : busy, 0);
        check_res(tag, which, v);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, which ? done0 : done, 0);
        chk({tag, "_pass_hold"}, which ? pass0 : pass, v.ps);
    endtask

    task automatic wait_x(input logic [4:0] target);
        int k = 0;
        while (x_out != target && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_x_out", x_out, target);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x_out"}, x_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_table"}, table_out, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_first_err"}, ferr, 0);
        chk({tag, "_first_vld"}, fvld, 0);
    endtask

    vec_t vt[4];

    initial begin
        vec_t v;
        bit   seen;
        vt[0] = '{fm: 0, g: 32'hFFFF_FFFF, tbl: 32'hFFFF_FFFF, err: 0,  first: 0, vld: 0, ps: 1};
        vt[1] = '{fm: 1, g: 32'hAAAA_AAAA, tbl: 32'hAAAA_AAAA, err: 0,  first: 0, vld: 0, ps: 1};
        vt[2] = '{fm: 1, g: 32'hAAAA_AA2A, tbl: 32'hAAAA_AAAA, err: 1,  first: 7, vld: 1, ps: 0};
        vt[3] = '{fm: 2, g: 32'hAAAA_AAAA, tbl: 32'h5555_5555, err: 32, first: 0, vld: 1, ps: 0};

        #2 rst_n = 1'b0;
        #10;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            scan($sformatf("vec%0d", i), 0, 0, vt[i], 65);

        for (int r = 0; r < 6; r++) begin
            logic [31:0] g;
            rnd_tbl = $urandom;
            case (r % 3)
                0:       g = rnd_tbl;
                1:       g = rnd_tbl ^ (32'h1 << $urandom_range(31, 0));
                default: g = $urandom;
            endcase
            scan($sformatf("rnd%0d", r), 0, 0, model(3, g, 32), 65);
        end

        // restart attempt and golden change mid-scan are both ignored
        scan("restart", 0, 1, vt[1], 65);

        // abort while x_out=10: sample 10 is dropped, partial results kept
        fmode = 2;
        @(negedge clk);
        golden = 32'hAAAA_AAAA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_x(5'd10);
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_upper_zero", table_out[31:10], 0);
        check_res("abort", 0, model(2, 32'hAAAA_AAAA, 10));

        // abort beats start in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("abort_start_idle", seen, 0);

        // asynchronous reset mid-scan clears outputs before the next edge
        fmode = 1;
        @(negedge clk);
        golden = 32'hAAAA_AAAA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_x(5'd20);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        scan("post_rst", 0, 0, vt[1], 65);

        // SETTLE=0 build
        scan("settle0", 1, 0, vt[1], 33);
        scan("settle0_err", 1, 0, vt[2], 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
